// File: rtl/mips_mul_div.sv
// MIPS HI/LO multiply-divide unit: 32-iteration shift-add multiplier and
// restoring divider sharing one 64-bit accumulator, plus MTHI/MTLO writes.
module mips_mul_div (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        signal_start,
  input  logic [1:0]  op,
  input  logic        signal_mthi,
  input  logic        signal_mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_raw;
  logic [31:0] addend;
  logic        neg_a;
  logic        neg_b;
  logic        div_zero;
  logic [63:0] acc;
  logic [4:0]  cnt;

  logic        sgn_in;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic [32:0] sum;
  logic [32:0] rsh;
  logic [32:0] diff;
  logic [63:0] acc_nxt;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign sgn_in   = ~op[0];
  assign a_mag_in = (sgn_in && operand_a[31]) ? -operand_a : operand_a;
  assign b_mag_in = (sgn_in && operand_b[31]) ? -operand_b : operand_b;

  always_comb begin
    sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, addend} : 33'd0);
    rsh     = {acc[63:32], acc[31]};
    diff    = rsh - {1'b0, addend};
    acc_nxt = {sum, acc[31:1]};
    if (op_q[1]) begin
      if (!diff[32])
        acc_nxt = {diff[31:0], acc[30:0], 1'b1};
      else
        acc_nxt = {rsh[31:0], acc[30:0], 1'b0};
    end
  end

  // Sign correction of the magnitude result from the final iteration
  always_comb begin
    prod   = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
    quo    = (neg_a ^ neg_b) ? -acc_nxt[31:0] : acc_nxt[31:0];
    rem    = neg_a ? -acc_nxt[63:32] : acc_nxt[63:32];
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (op_q[1]) begin
      res_hi = div_zero ? a_raw : rem;
      res_lo = div_zero ? 32'hFFFF_FFFF : quo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= 2'd0;
      a_raw    <= 32'd0;
      addend   <= 32'd0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= 64'd0;
      cnt      <= 5'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, FINISH: begin
          if (signal_start) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= 5'd0;
            op_q     <= op;
            a_raw    <= operand_a;
            neg_a    <= sgn_in & operand_a[31];
            neg_b    <= sgn_in & operand_b[31];
            div_zero <= (operand_b == 32'd0);
            addend   <= op[1] ? b_mag_in : a_mag_in;
            acc      <= {32'd0, op[1] ? a_mag_in : b_mag_in};
          end else begin
            state <= IDLE;
            if (signal_mthi) hi <= operand_a;
            if (signal_mtlo) lo <= operand_a;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
